// File: rtl/nes_rom_fetcher_if.sv
// AXI4 read-channel bundle between nes_rom_fetcher (master) and system memory (slave).
// Only the AR and R channels exist; the fetcher never writes.
//   arvalid/araddr/arlen/arsize/arburst : read address request, master -> slave
//   arready                             : address accepted, slave -> master
//   rvalid/rresp/rdata/rlast            : read data beat, slave -> master
//   rready                              : beat accepted, master -> slave
interface nes_rom_fetcher_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arready;
  logic              rvalid;
  logic              rready;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rresp, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rresp, rdata, rlast
  );
endinterface

// File: rtl/nes_rom_fetcher.sv
// nes_rom_fetcher: AXI4 read master that streams a ROM image from system memory
// into the game_loader byte interface. The image is split into INCR bursts that
// never cross a 4KB boundary; each data beat is held in a one-beat buffer and
// emitted little-endian as paced single-cycle byte strobes.
// Ports:
//   i_axi_clk, i_axi_rst     clock, synchronous active-low reset
//   i_start                  1-cycle start pulse, ignored while o_busy
//   i_base_addr, i_length    image address (beat-aligned internally) and byte count
//   o_busy, o_done, o_error  status; done/error are 1-cycle pulses
//   o_downloading            game_loader.downloading
//   o_loader_data/strobe     game_loader.indata / indata_clk
//   master                   AXI4 AR/R channels (nes_rom_fetcher_if.master)
module nes_rom_fetcher #(
  parameter int M_ADDR_WIDTH  = 32,
  parameter int M_DATA_WIDTH  = 64,
  parameter int MAX_BURST_LEN = 16,
  parameter int BYTE_GAP      = 0
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_start,
  input  logic [M_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [24:0]             i_length,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic                    o_downloading,
  output logic [7:0]              o_loader_data,
  output logic                    o_loader_strobe,
  nes_rom_fetcher_if.master       master
);
  localparam int NB    = M_DATA_WIDTH / 8;
  localparam int NB_W  = $clog2(NB);
  localparam int CNT_W = NB_W + 1;
  localparam int GAP_W = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_SHIFT, S_DONE, S_DRAIN, S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [M_ADDR_WIDTH-1:0] cur_addr_q;
  logic [24:0]             bytes_left_q;
  logic [M_DATA_WIDTH-1:0] beat_q;       // shifts right one byte per strobe
  logic [CNT_W-1:0]        beat_cnt_q;   // bytes still to emit from beat_q
  logic [GAP_W-1:0]        gap_q;        // idle cycles before next strobe
  logic                    beat_last_q;  // buffered beat carried rlast

  logic [25:0]             beats_left;
  logic [12:0]             beats_4k;
  logic [25:0]             burst_beats;
  logic [7:0]              arlen_c;
  logic                    rresp_err;
  logic                    strobe;
  logic                    last_in_beat;
  logic [CNT_W-1:0]        take_n;

  // Burst sizing: remaining beats, capped by MAX_BURST_LEN and by the
  // distance to the next 4KB page (AXI bursts must not cross it).
  assign beats_left = ({1'b0, bytes_left_q} + 26'(NB - 1)) >> NB_W;
  assign beats_4k   = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> NB_W;

  always_comb begin
    burst_beats = beats_left;
    if (burst_beats > 26'(MAX_BURST_LEN)) burst_beats = 26'(MAX_BURST_LEN);
    if (burst_beats > 26'(beats_4k))      burst_beats = 26'(beats_4k);
  end

  assign arlen_c      = 8'(burst_beats - 26'd1);
  // SLVERR (2'b10) and DECERR (2'b11) both abort.
  assign rresp_err    = (master.rresp == 2'b10) || (master.rresp == 2'b11);
  assign strobe       = (state_q == S_SHIFT) && (gap_q == '0);
  assign last_in_beat = (beat_cnt_q == CNT_W'(1));
  // A short final beat only yields the bytes still owed; the rest is dropped.
  assign take_n       = (bytes_left_q >= 25'(NB)) ? CNT_W'(NB) : bytes_left_q[CNT_W-1:0];

  // ---------------- state register ----------------
  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // DONE/ERR are idle for start purposes, so a start on the pulse cycle is not lost.
      S_IDLE, S_DONE, S_ERR: begin
        state_d = S_IDLE;
        if (i_start) state_d = (i_length == 25'd0) ? S_DONE : S_ADDR;
      end
      S_ADDR: if (master.arready) state_d = S_DATA;
      S_DATA: begin
        if (master.rvalid) begin
          if (rresp_err) state_d = master.rlast ? S_ERR : S_DRAIN;
          else           state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (strobe && last_in_beat) begin
          if (bytes_left_q == 25'd1) state_d = S_DONE;
          else if (beat_last_q)      state_d = S_ADDR;
          else                       state_d = S_DATA;
        end
      end
      S_DRAIN: if (master.rvalid && master.rlast) state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge i_axi_clk) begin
    if (!i_axi_rst) begin
      cur_addr_q   <= '0;
      bytes_left_q <= '0;
      beat_q       <= '0;
      beat_cnt_q   <= '0;
      gap_q        <= '0;
      beat_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            cur_addr_q   <= i_base_addr & ~M_ADDR_WIDTH'(NB - 1);
            bytes_left_q <= i_length;
          end
        end
        // Advance to the next burst as soon as this one is accepted;
        // araddr is only driven in ADDR so nothing observes the early update.
        S_ADDR: begin
          if (master.arready)
            cur_addr_q <= cur_addr_q + (M_ADDR_WIDTH'(burst_beats) << NB_W);
        end
        S_DATA: begin
          if (master.rvalid && !rresp_err) begin
            beat_q      <= master.rdata;
            beat_cnt_q  <= take_n;
            gap_q       <= '0;
            beat_last_q <= master.rlast;
          end
        end
        S_SHIFT: begin
          if (strobe) begin
            beat_q       <= beat_q >> 8;
            beat_cnt_q   <= beat_cnt_q - CNT_W'(1);
            bytes_left_q <= bytes_left_q - 25'd1;
            gap_q        <= GAP_W'(BYTE_GAP);
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    o_busy          = 1'b0;
    o_downloading   = 1'b0;
    o_done          = 1'b0;
    o_error         = 1'b0;
    o_loader_strobe = strobe;
    o_loader_data   = strobe ? beat_q[7:0] : 8'h00;
    master.arvalid  = 1'b0;
    master.araddr   = '0;
    master.arlen    = '0;
    master.arsize   = '0;
    master.arburst  = '0;
    master.rready   = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        o_busy         = 1'b1;
        o_downloading  = 1'b1;
        master.arvalid = 1'b1;
        master.araddr  = cur_addr_q;
        master.arlen   = arlen_c;
        master.arsize  = 3'(NB_W);
        master.arburst = 2'b01;  // INCR
      end
      S_DATA, S_DRAIN: begin
        o_busy        = 1'b1;
        o_downloading = 1'b1;
        master.rready = 1'b1;
      end
      S_SHIFT: begin
        o_busy        = 1'b1;
        o_downloading = 1'b1;
      end
      S_DONE:  o_done  = 1'b1;
      S_ERR:   o_error = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_nes_rom_fetcher.sv
// Bench: two fetchers (BYTE_GAP 0 and 2) against a small AXI memory model whose
// byte at address a is a[7:0]. Stimulus pushes expected bytes, AR requests and
// end events into queues; one negedge monitor pops and compares.
module tb_nes_rom_fetcher;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        start;
  logic [31:0]       base;
  logic [24:0]       len;
  logic [1:0]        busy, done, err, dl, stb, arv, arr, rrdy, drained;
  logic [1:0][7:0]   ldat;
  logic [1:0][31:0]  araddr;
  logic [1:0][7:0]   arlen;

  int ar_delay  = 0;
  int rgap_rand = 0;
  int err_beat  = -1;

  int   cyc      = 0;
  logic rst_edge = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  function automatic logic [63:0] beat_pat(input logic [31:0] a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(a + 32'(k));
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int GAP = (g == 0) ? 0 : 2;
    nes_rom_fetcher_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    nes_rom_fetcher #(
      .M_ADDR_WIDTH(32), .M_DATA_WIDTH(64), .MAX_BURST_LEN(16), .BYTE_GAP(GAP)
    ) u_dut (
      .i_axi_clk(clk), .i_axi_rst(rst_n), .i_start(start[g]),
      .i_base_addr(base), .i_length(len),
      .o_busy(busy[g]), .o_done(done[g]), .o_error(err[g]),
      .o_downloading(dl[g]), .o_loader_data(ldat[g]), .o_loader_strobe(stb[g]),
      .master(bus)
    );

    assign arv[g]     = bus.arvalid;
    assign arr[g]     = bus.arready;
    assign rrdy[g]    = bus.rready;
    assign araddr[g]  = bus.araddr;
    assign arlen[g]   = bus.arlen;

    // memory slave: one outstanding burst, optional random rvalid gaps
    logic [31:0] s_addr;
    int          s_left;
    int          ar_wait;
    int          beat_no;
    assign drained[g] = (s_left == 0) && !bus.rvalid;

    always @(posedge clk) begin
      if (!rst_n) begin
        bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rlast <= 1'b0;
        bus.rresp <= 2'b00; bus.rdata <= '0;
        s_addr <= '0; s_left <= 0; ar_wait <= 0; beat_no <= 0;
      end else begin
        if (start[g]) beat_no <= 0;
        if (bus.arvalid && bus.arready) begin
          bus.arready <= 1'b0;
          s_addr      <= bus.araddr;
          s_left      <= int'(bus.arlen) + 1;
          ar_wait     <= 0;
        end else if (bus.arvalid && !bus.arready && s_left == 0 && !bus.rvalid) begin
          if (ar_wait >= ar_delay) bus.arready <= 1'b1;
          else                     ar_wait <= ar_wait + 1;
        end
        if (!bus.rvalid || bus.rready) begin
          if (s_left > 0 && !(rgap_rand != 0 && $urandom_range(0, 2) == 0)) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= beat_pat(s_addr);
            bus.rlast  <= (s_left == 1);
            bus.rresp  <= (beat_no == err_beat) ? 2'b10 : 2'b00;
            s_addr     <= s_addr + 32'd8;
            s_left     <= s_left - 1;
            beat_no    <= beat_no + 1;
          end else begin
            bus.rvalid <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_bytes[$];
  logic [39:0] exp_ar[$];     // {araddr, arlen}
  int          exp_ev[$];     // 0 done, 1 error, 2 zero-length done
  int          start_cyc = 0;
  int          tmo_cnt   = 0;
  logic        end_req   = 1'b0;

  int   nchk = 0, nfail = 0;
  int   byte_no = 0, last_stb = 0, tmo_seen = 0, ev;
  logic dl_seen = 1'b0, first_ar = 1'b1, end_done = 1'b0;
  logic [7:0]  eb;
  logic [39:0] ea;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_edge) begin
      for (int g = 0; g < 2; g++) begin
        check("reset_flags", 32'({busy[g], done[g], err[g], dl[g], stb[g], arv[g], rrdy[g]}), 32'd0);
        check("reset_data", 32'(ldat[g]), 32'd0);
        check("reset_araddr", araddr[g], 32'd0);
      end
      byte_no = 0; dl_seen = 1'b0; first_ar = 1'b1;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (arv[g]) begin
          if (first_ar) check("ar_latency", 32'(cyc - start_cyc), 32'd1);
          first_ar = 1'b0;
          check("dl_at_ar", 32'(dl[g]), 32'd1);
          if (exp_ar.size() == 0) check("ar_unexpected", araddr[g], 32'hffff_ffff);
          else begin
            ea = exp_ar[0];
            check("araddr", araddr[g], ea[39:8]);
            check("arlen", 32'(arlen[g]), 32'(ea[7:0]));
            if (arr[g]) void'(exp_ar.pop_front());
          end
        end
        if (stb[g]) begin
          check("dl_at_strobe", 32'(dl[g]), 32'd1);
          if (exp_bytes.size() == 0) check("strobe_unexpected", 32'(ldat[g]), 32'h100);
          else begin
            eb = exp_bytes.pop_front();
            check("byte", 32'(ldat[g]), 32'(eb));
          end
          if (byte_no % 8 != 0) check("strobe_spacing", 32'(cyc - last_stb), (g == 0) ? 32'd1 : 32'd3);
          last_stb = cyc;
          byte_no++;
        end
        if (dl[g]) dl_seen = 1'b1;
        if (done[g] || err[g]) begin
          if (exp_ev.size() == 0) check("event_unexpected", 32'({done[g], err[g]}), 32'd0);
          else begin
            ev = exp_ev.pop_front();
            check("event_kind", 32'({done[g], err[g]}), (ev == 1) ? 32'd1 : 32'd2);
            check("end_busy_dl", 32'({busy[g], dl[g]}), 32'd0);
            check("bytes_pending", 32'(exp_bytes.size()), 32'd0);
            if (ev == 2) begin
              check("len0_dl_seen", 32'(dl_seen), 32'd0);
              check("len0_latency_1to2", 32'((cyc - start_cyc >= 1) && (cyc - start_cyc <= 2)), 32'd1);
            end else if (ev == 0) begin
              check("done_after_last", 32'(cyc - last_stb), 32'd1);
            end else begin
              check("drained_to_rlast", 32'(drained[g]), 32'd1);
            end
          end
          byte_no = 0; dl_seen = 1'b0; first_ar = 1'b1;
        end
      end
    end
    if (tmo_cnt != tmo_seen) begin
      check("wait_timeout", 32'(tmo_cnt - tmo_seen), 32'd0);
      tmo_seen = tmo_cnt;
    end
    if (end_req && !end_done) begin
      check("end_bytes_left", 32'(exp_bytes.size()), 32'd0);
      check("end_ar_left", 32'(exp_ar.size()), 32'd0);
      check("end_ev_left", 32'(exp_ev.size()), 32'd0);
      end_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_bytes(input logic [31:0] b, input int l);
    for (int i = 0; i < l; i++) exp_bytes.push_back(8'(b + 32'(i)));
  endtask

  task automatic start_xfer(input int g, input logic [31:0] b, input logic [24:0] l);
    @(negedge clk);
    base = b; len = l; start[g] = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_ev(input int bound);
    int n = 0;
    while (exp_ev.size() != 0 && n < bound) begin @(negedge clk); n++; end
    if (exp_ev.size() != 0) begin
      tmo_cnt++;
      exp_ev.delete(); exp_bytes.delete(); exp_ar.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_t1(input int g);
    push_bytes(32'h1000_0000, 20);
    exp_ar.push_back({32'h1000_0000, 8'd2});
    exp_ev.push_back(0);
    start_xfer(g, 32'h1000_0000, 25'd20);
    wait_ev(600);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = '0; base = '0; len = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single 3-beat burst, partial last beat
    run_t1(0);

    // 2: zero length, no AXI traffic
    exp_ev.push_back(2);
    start_xfer(0, 32'h2000_0000, 25'd0);
    wait_ev(20);

    // 3: 4KB split + MAX_BURST_LEN cap; a start while busy must be ignored
    push_bytes(32'h0000_0FC0, 256);
    exp_ar.push_back({32'h0000_0FC0, 8'd7});
    exp_ar.push_back({32'h0000_1000, 8'd15});
    exp_ar.push_back({32'h0000_1080, 8'd7});
    exp_ev.push_back(0);
    start_xfer(0, 32'h0000_0FC0, 25'd256);
    repeat (30) @(negedge clk);
    base = 32'h2000; len = 25'd8; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_ev(2000);

    // 4: bad rresp on second beat of a 4-beat burst, then a clean transfer
    err_beat = 1;
    push_bytes(32'h0000_3000, 8);
    exp_ar.push_back({32'h0000_3000, 8'd3});
    exp_ev.push_back(1);
    start_xfer(0, 32'h0000_3000, 25'd32);
    wait_ev(400);
    err_beat = -1;
    push_bytes(32'h0000_4000, 16);
    exp_ar.push_back({32'h0000_4000, 8'd1});
    exp_ev.push_back(0);
    start_xfer(0, 32'h0000_4000, 25'd16);
    wait_ev(400);

    // 5: slow arready, random rvalid gaps, BYTE_GAP=2 instance
    ar_delay = 5; rgap_rand = 1;
    run_t1(1);
    ar_delay = 0; rgap_rand = 0;

    // 6: reset while shifting, then a normal transfer
    push_bytes(32'h1000_0000, 20);
    exp_ar.push_back({32'h1000_0000, 8'd2});
    exp_ev.push_back(0);
    start_xfer(0, 32'h1000_0000, 25'd20);
    n = 0;
    while (!stb[0] && n < 200) begin @(negedge clk); n++; end
    if (!stb[0]) tmo_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_bytes.delete(); exp_ar.delete(); exp_ev.delete();
    repeat (2) @(negedge clk);
    run_t1(0);

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
